// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit and the decoder
// that drives its op/start inputs.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6,
    MDU_RSVD  = 3'd7
  } mdu_op_e;

  localparam int MUL_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF = 10;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  function automatic logic is_valid_op(input logic [2:0] op);
    return is_muldiv(op) || (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multiply/divide unit with architectural HI/LO: fixed-latency MULT/DIV,
// single-cycle MTHI/MTLO, and a combinational busy for the stall unit.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  op,
  input  logic        start,
  input  logic        cancel,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] MUL_CNT = CW'(MUL_CYCLES);
  localparam logic [CW-1:0] DIV_CNT = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic          res_valid_q, res_valid_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          accept;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, q_u, r_u;
  logic [31:0] mag_a, mag_b, mag_b_nz, q_mag, r_mag, q_s, r_s;

  // The lower 64 bits of the sign-extended product equal the signed product.
  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'b0, a} * {32'b0, b};

  // Divide-by-zero is steered to 1 so no X reaches the pending register;
  // that result is flagged invalid and never written.
  assign div_b    = (b == 32'd0) ? 32'd1 : b;
  assign q_u      = a / div_b;
  assign r_u      = a % div_b;
  assign mag_a    = a[31] ? (~a + 32'd1) : a;
  assign mag_b    = b[31] ? (~b + 32'd1) : b;
  assign mag_b_nz = (mag_b == 32'd0) ? 32'd1 : mag_b;
  assign q_mag    = mag_a / mag_b_nz;
  assign r_mag    = mag_a % mag_b_nz;
  assign q_s      = (a[31] ^ b[31]) ? (~q_mag + 32'd1) : q_mag;
  assign r_s      = a[31] ? (~r_mag + 32'd1) : r_mag;

  assign accept = start && !cancel && !busy_q && is_valid_op(op);
  assign busy   = busy_q || (start && !cancel && is_muldiv(op));
  assign hi     = hi_q;
  assign lo     = lo_q;

  always_comb begin
    hi_d        = hi_q;
    lo_d        = lo_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    if (busy_q) begin
      if (cnt_q == CNT_ONE) begin
        busy_d = 1'b0;
        cnt_d  = '0;
        if (res_valid_q) begin
          hi_d = res_hi_q;
          lo_d = res_lo_q;
        end
      end else begin
        cnt_d = cnt_q - CNT_ONE;
      end
    end else if (accept) begin
      unique case (mdu_op_e'(op))
        MDU_MULT, MDU_MULTU: begin
          {res_hi_d, res_lo_d} = (op == MDU_MULT) ? prod_s : prod_u;
          res_valid_d = 1'b1;
          busy_d      = 1'b1;
          cnt_d       = MUL_CNT;
        end
        MDU_DIV, MDU_DIVU: begin
          res_lo_d    = (op == MDU_DIV) ? q_s : q_u;
          res_hi_d    = (op == MDU_DIV) ? r_s : r_u;
          res_valid_d = (b != 32'd0);
          busy_d      = 1'b1;
          cnt_d       = DIV_CNT;
        end
        MDU_MTHI: hi_d = a;
        MDU_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q        <= '0;
      lo_q        <= '0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, hand-written
// cancel/reset/MT sequences, and randomized ops against an arithmetic model.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  logic        clk;
  logic        reset;
  logic [2:0]  op;
  logic        start;
  logic        cancel;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks;
  int errors;
  logic [31:0] mdl_hi;
  logic [31:0] mdl_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  mdu_unit #(.MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk(clk), .reset(reset), .op(op), .start(start), .cancel(cancel),
    .a(a), .b(b), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The stall unit guarantees no new op reaches E while the unit is occupied.
  always @(negedge clk) begin
    if (reset && start)
      assert (!dut.busy_q) else $error("[TB] FAIL start_while_busy: start=1 busy_reg=1 required busy_reg=0");
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Architectural effect of one op straight from the ISA definition.
  task automatic model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input bit canc, output logic [31:0] nhi, output logic [31:0] nlo,
                          output int lat);
    longint sx, sy, p;
    logic [63:0] pu;
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    nhi = mdl_hi;
    nlo = mdl_lo;
    lat = 0;
    if (!canc) begin
      case (o)
        3'd1: begin p = sx * sy; {nhi, nlo} = p; lat = MUL_LAT; end
        3'd2: begin pu = 64'(x) * 64'(y); {nhi, nlo} = pu; lat = MUL_LAT; end
        3'd3: begin
          lat = DIV_LAT;
          if (y != 0) begin nlo = 32'(sx / sy); nhi = 32'(sx % sy); end
        end
        3'd4: begin
          lat = DIV_LAT;
          if (y != 0) begin nlo = x / y; nhi = x % y; end
        end
        3'd5: nhi = x;
        3'd6: nlo = x;
        default: ;
      endcase
    end
  endtask

  // Issue one op for a single cycle, then follow it to completion.
  task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                input bit canc, input bit pulse_cancel,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                input int lat, input string name);
    @(posedge clk); #1;
    op = o; a = x; b = y; start = 1'b1; cancel = canc;
    #1 check_output({name, " busy_start"}, 64'(busy), 64'(lat > 0));
    @(posedge clk); #1;
    start = 1'b0; cancel = 1'b0; op = 3'd0; a = $urandom; b = $urandom;
    for (int i = 1; i <= lat; i++) begin
      cancel = pulse_cancel && (i == 2);
      #1;
      check_output($sformatf("%s busy_c%0d", name, i), 64'(busy), 64'd1);
      check_output($sformatf("%s hi_hold_c%0d", name, i), 64'(hi), 64'(mdl_hi));
      check_output($sformatf("%s lo_hold_c%0d", name, i), 64'(lo), 64'(mdl_lo));
      @(posedge clk); #1;
      cancel = 1'b0;
    end
    #1;
    check_output({name, " busy_done"}, 64'(busy), 64'd0);
    check_output({name, " hi"}, 64'(hi), 64'(exp_hi));
    check_output({name, " lo"}, 64'(lo), 64'(exp_lo));
    mdl_hi = exp_hi;
    mdl_lo = exp_lo;
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] rx, ry, eh, el;
    bit          rc, rp;
    int          rl;

    checks = 0; errors = 0;
    mdl_hi = '0; mdl_lo = '0;
    reset = 1'b0; op = 3'd0; start = 1'b0; cancel = 1'b0; a = '0; b = '0;

    vecs[0] = '{3'd1, 32'hFFFFFFFE, 32'd3,          32'hFFFFFFFF, 32'hFFFFFFFA, MUL_LAT};
    vecs[1] = '{3'd2, 32'hFFFFFFFE, 32'd3,          32'h00000002, 32'hFFFFFFFA, MUL_LAT};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'd2,          32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
    vecs[3] = '{3'd4, 32'd7,        32'd2,          32'd1,        32'd3,        DIV_LAT};
    vecs[4] = '{3'd5, 32'h11,       32'h0,          32'h11,       32'd3,        0};
    vecs[5] = '{3'd6, 32'h22,       32'h0,          32'h11,       32'h22,       0};
    vecs[6] = '{3'd3, 32'd5,        32'd0,          32'h11,       32'h22,       DIV_LAT};
    vecs[7] = '{3'd3, 32'h80000000, 32'hFFFFFFFF,   32'h0,        32'h80000000, DIV_LAT};
    vecs[8] = '{3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,   32'hFFFFFFFE, 32'h00000001, MUL_LAT};
    vecs[9] = '{3'd3, 32'd7,        32'hFFFFFFFE,   32'h1,        32'hFFFFFFFD, DIV_LAT};

    #3;
    check_output("reset busy", 64'(busy), 64'd0);
    check_output("reset hi", 64'(hi), 64'd0);
    check_output("reset lo", 64'(lo), 64'd0);
    @(posedge clk); #1 reset = 1'b1;

    for (int i = 0; i < 10; i++)
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0,
                     vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat, $sformatf("vec%0d", i));

    // Back-to-back MTHI/MTLO on consecutive cycles.
    @(posedge clk); #1;
    op = 3'd5; a = 32'hDEADBEEF; start = 1'b1;
    #1 check_output("mthi busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    op = 3'd6; a = 32'h00001234;
    #1;
    check_output("mthi hi", 64'(hi), 64'hDEADBEEF);
    check_output("mtlo busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; op = 3'd0;
    #1;
    check_output("mtlo hi", 64'(hi), 64'hDEADBEEF);
    check_output("mtlo lo", 64'(lo), 64'h00001234);
    mdl_hi = 32'hDEADBEEF; mdl_lo = 32'h00001234;

    // MULT killed by cancel in its start cycle never lands.
    apply_stimulus(3'd1, 32'd9, 32'd9, 1'b1, 1'b0, mdl_hi, mdl_lo, 0, "mult_cancelled");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      check_output($sformatf("cancelled hi_c%0d", i), 64'(hi), 64'hDEADBEEF);
      check_output($sformatf("cancelled lo_c%0d", i), 64'(lo), 64'h00001234);
    end

    // Cancel after acceptance has no effect on the committed MULT.
    apply_stimulus(3'd1, 32'd6, 32'd7, 1'b0, 1'b1, 32'd0, 32'd42, MUL_LAT, "mult_late_cancel");

    // Asynchronous reset in the middle of a DIV.
    @(posedge clk); #1;
    op = 3'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0; op = 3'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check_output("midreset busy", 64'(busy), 64'd0);
    check_output("midreset hi", 64'(hi), 64'd0);
    check_output("midreset lo", 64'(lo), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    mdl_hi = '0; mdl_lo = '0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #2;
      check_output($sformatf("postreset lo_c%0d", i), 64'(lo), 64'd0);
    end
    apply_stimulus(3'd1, 32'd4, 32'd5, 1'b0, 1'b0, 32'd0, 32'd20, MUL_LAT, "mult_after_reset");

    for (int n = 0; n < 40; n++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
      rc = ($urandom_range(0, 7) == 0);
      rp = ($urandom_range(0, 3) == 0);
      model_op(ro, rx, ry, rc, eh, el, rl);
      apply_stimulus(ro, rx, ry, rc, rp, eh, el, rl, $sformatf("rand%0d_op%0d", n, ro));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
